// File: rtl/uart_link_pkg.sv
// Shared types and constants for the uart_link transceiver.
package uart_link_pkg;

    localparam int unsigned UART_DATA_BITS = 8;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_t;

    // Bit period in clock cycles, truncated.
    function automatic int unsigned calc_div(input int unsigned clk_freq, input int unsigned baud);
        return clk_freq / baud;
    endfunction

endpackage

// File: rtl/uart_link_if.sv
// Holding-register handshake between uart_link and the control unit.
interface uart_link_if;
    import uart_link_pkg::*;

    logic [UART_DATA_BITS-1:0] data_in;
    logic                      wen;
    logic                      txrdy;
    logic [UART_DATA_BITS-1:0] data_out;
    logic                      oen;
    logic                      rxrdy;
    logic                      framing_err;
    logic                      overflow;

    modport master (
        output data_in, wen, oen,
        input  txrdy, data_out, rxrdy, framing_err, overflow
    );

    modport slave (
        input  data_in, wen, oen,
        output txrdy, data_out, rxrdy, framing_err, overflow
    );

endinterface

// File: rtl/uart_link_rx_fsm.sv
// Receive side: rx synchroniser, 8N1 deframing FSM and shift register.
module uart_rx_fsm
    import uart_link_pkg::*;
#(
    parameter int unsigned DIV = 10
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      i_rx,
    output logic                      o_done,
    output logic [UART_DATA_BITS-1:0] o_byte,
    output logic                      o_stop
);

    localparam int unsigned CW = $clog2(DIV);
    localparam int unsigned BW = $clog2(UART_DATA_BITS);
    localparam logic [CW-1:0] CNT_LAST  = CW'(DIV - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(DIV / 2 - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(UART_DATA_BITS - 1);

    logic                      r_sync1, r_sync2, r_rx_d;
    uart_state_t               r_state, w_state_nx;
    logic [CW-1:0]             r_cnt;
    logic [BW-1:0]             r_bit;
    logic [UART_DATA_BITS-1:0] r_shift;
    logic                      w_rx_s, w_cnt_clr, w_shift_en, w_done;

    assign w_rx_s = r_sync2;

    always_comb begin
        w_state_nx = r_state;
        w_cnt_clr  = 1'b0;
        w_shift_en = 1'b0;
        w_done     = 1'b0;
        case (r_state)
            IDLE: begin
                w_cnt_clr = 1'b1;
                if (!w_rx_s && r_rx_d) w_state_nx = START;
            end
            START: begin
                // Mid start bit: a line back high is treated as a glitch.
                if (r_cnt == HALF_LAST) begin
                    w_cnt_clr  = 1'b1;
                    w_state_nx = w_rx_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (r_cnt == CNT_LAST) begin
                    w_cnt_clr  = 1'b1;
                    w_shift_en = 1'b1;
                    if (r_bit == BIT_LAST) w_state_nx = STOP;
                end
            end
            STOP: begin
                if (r_cnt == CNT_LAST) begin
                    w_cnt_clr  = 1'b1;
                    w_done     = 1'b1;
                    w_state_nx = IDLE;
                end
            end
            default: w_state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_rx_d  <= 1'b1;
            r_state <= IDLE;
            r_cnt   <= '0;
            r_bit   <= '0;
            r_shift <= '0;
        end else begin
            r_sync1 <= i_rx;
            r_sync2 <= r_sync1;
            r_rx_d  <= w_rx_s;
            r_state <= w_state_nx;
            r_cnt   <= w_cnt_clr ? '0 : r_cnt + 1'b1;
            if (r_state != DATA)
                r_bit <= '0;
            else if (w_shift_en)
                r_bit <= r_bit + 1'b1;
            if (w_shift_en)
                r_shift <= {w_rx_s, r_shift[UART_DATA_BITS-1:1]};
        end
    end

    assign o_done = w_done;
    assign o_byte = r_shift;
    assign o_stop = w_rx_s;

endmodule

// File: rtl/uart_link.sv
// 8N1 UART transceiver with holding-register handshake for the control unit.
module uart_link
    import uart_link_pkg::*;
#(
    parameter int unsigned CLK_FREQ = 50_000_000,
    parameter int unsigned BAUD     = 115200
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      rx,
    output logic      tx,
    uart_link_if.slave bus
);

    localparam int unsigned DIV = calc_div(CLK_FREQ, BAUD);
    localparam int unsigned CW  = $clog2(DIV);
    localparam int unsigned BW  = $clog2(UART_DATA_BITS);
    localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(UART_DATA_BITS - 1);

    uart_state_t               r_tx_state, w_tx_state_nx;
    logic [CW-1:0]             r_tx_cnt;
    logic [BW-1:0]             r_tx_bit;
    logic [UART_DATA_BITS-1:0] r_hold, r_shift;
    logic                      r_hold_full;
    logic                      w_load, w_cnt_done, w_tx, w_accept;

    logic [UART_DATA_BITS-1:0] r_data_out;
    logic                      r_rxrdy, r_fe, r_ov;
    logic                      w_rx_done, w_rx_stop;
    logic [UART_DATA_BITS-1:0] w_rx_byte;

    assign w_cnt_done = (r_tx_cnt == CNT_LAST);
    assign w_accept   = bus.wen && !r_hold_full;

    always_comb begin
        w_tx_state_nx = r_tx_state;
        w_load        = 1'b0;
        w_tx          = 1'b1;
        case (r_tx_state)
            IDLE: begin
                if (r_hold_full) begin
                    w_load        = 1'b1;
                    w_tx_state_nx = START;
                end
            end
            START: begin
                w_tx = 1'b0;
                if (w_cnt_done) w_tx_state_nx = DATA;
            end
            DATA: begin
                w_tx = r_shift[0];
                if (w_cnt_done && r_tx_bit == BIT_LAST) w_tx_state_nx = STOP;
            end
            STOP: begin
                if (w_cnt_done) w_tx_state_nx = IDLE;
            end
            default: w_tx_state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tx_state  <= IDLE;
            r_tx_cnt    <= '0;
            r_tx_bit    <= '0;
            r_hold      <= '0;
            r_shift     <= '0;
            r_hold_full <= 1'b0;
        end else begin
            r_tx_state <= w_tx_state_nx;
            r_tx_cnt   <= (r_tx_state == IDLE || w_cnt_done) ? '0 : r_tx_cnt + 1'b1;
            if (r_tx_state != DATA)
                r_tx_bit <= '0;
            else if (w_cnt_done)
                r_tx_bit <= r_tx_bit + 1'b1;
            if (w_load)
                r_shift <= r_hold;
            else if (r_tx_state == DATA && w_cnt_done)
                r_shift <= r_shift >> 1;
            if (w_accept) begin
                r_hold      <= bus.data_in;
                r_hold_full <= 1'b1;
            end else if (w_load) begin
                r_hold_full <= 1'b0;
            end
        end
    end

    uart_rx_fsm #(.DIV(DIV)) u_rx (
        .clk    (clk),
        .rst    (rst),
        .i_rx   (rx),
        .o_done (w_rx_done),
        .o_byte (w_rx_byte),
        .o_stop (w_rx_stop)
    );

    // A read in the delivery cycle frees the register for the new byte.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_data_out <= '0;
            r_rxrdy    <= 1'b0;
            r_fe       <= 1'b0;
            r_ov       <= 1'b0;
        end else begin
            if (w_rx_done)
                r_rxrdy <= 1'b1;
            else if (bus.oen)
                r_rxrdy <= 1'b0;
            if (w_rx_done && (!r_rxrdy || bus.oen))
                r_data_out <= w_rx_byte;
            r_fe <= (r_fe & ~bus.oen) | (w_rx_done & ~w_rx_stop);
            r_ov <= (r_ov & ~bus.oen) | (w_rx_done & r_rxrdy & ~bus.oen);
        end
    end

    assign tx              = w_tx;
    assign bus.txrdy       = !r_hold_full;
    assign bus.data_out    = r_data_out;
    assign bus.rxrdy       = r_rxrdy;
    assign bus.framing_err = r_fe;
    assign bus.overflow    = r_ov;

endmodule

// File: tb/tb_uart_link.sv
// Self-checking bench for uart_link at DIV=10, with a line-level frame decoder and RX scoreboard.
module tb_uart_link;

    logic clk, rst, rx, tx;
    uart_link_if u_if();

    uart_link #(.CLK_FREQ(1_000_000), .BAUD(100_000)) dut (
        .clk (clk),
        .rst (rst),
        .rx  (rx),
        .tx  (tx),
        .bus (u_if)
    );

    int n_total = 0;
    int n_bad   = 0;
    int cyc     = 0;
    int rise_idx;
    int lat;

    logic [8:0] txq[$];
    int         txt[$];
    logic [7:0] exq[$];

    logic       m_pend, m_fe, m_ov;
    logic [7:0] m_data;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc++;

    initial begin
        #1ms;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Decodes whatever appears on tx by sampling bit centres.
    initial begin : tx_monitor
        logic       prev;
        logic [7:0] mb;
        int         t0;
        prev = 1'b1;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev = 1'b1;
            end else if (prev && !tx) begin
                t0 = cyc;
                repeat (4) @(negedge clk);
                for (int k = 0; k < 8; k++) begin
                    repeat (10) @(negedge clk);
                    mb[k] = tx;
                end
                repeat (10) @(negedge clk);
                txq.push_back({tx, mb});
                txt.push_back(t0);
                prev = tx;
            end else begin
                prev = tx;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic tx_write(input logic [7:0] b);
        u_if.data_in = b;
        u_if.wen     = 1'b1;
        tick();
        u_if.wen     = 1'b0;
    endtask

    task automatic wait_txrdy();
        int n = 0;
        while (!u_if.txrdy && n < 300) begin
            tick();
            n++;
        end
        if (!u_if.txrdy) check_eq("txrdy_timeout", u_if.txrdy, 1);
    endtask

    task automatic expect_tx(input logic [7:0] b);
        logic [8:0] f;
        check_eq("tx_frame_present", 32'(txq.size() != 0), 1);
        if (txq.size() != 0) begin
            f = txq.pop_front();
            check_eq("tx_frame", f, {1'b1, b});
        end
    endtask

    task automatic send_rx(input logic [7:0] b, input logic stopb, input int oen_at);
        logic [9:0] fr;
        fr = {stopb, b, 1'b0};
        rise_idx = -1;
        for (int i = 0; i < 100; i++) begin
            rx       = fr[i / 10];
            u_if.oen = (i == oen_at);
            tick();
            if (rise_idx < 0 && u_if.rxrdy) rise_idx = i;
        end
        u_if.oen = 1'b0;
        rx       = 1'b1;
    endtask

    task automatic read_pulse();
        u_if.oen = 1'b1;
        tick();
        u_if.oen = 1'b0;
    endtask

    task automatic rx_compare(input string tag);
        check_eq({tag, ".rxrdy"}, u_if.rxrdy, m_pend);
        check_eq({tag, ".data"}, u_if.data_out, m_data);
        check_eq({tag, ".fe"}, u_if.framing_err, m_fe);
        check_eq({tag, ".ov"}, u_if.overflow, m_ov);
    endtask

    initial begin
        logic [9:0] bits;
        logic [7:0] b;
        logic       sb, coinc;

        rst = 1'b1; rx = 1'b1;
        u_if.wen = 1'b0; u_if.oen = 1'b0; u_if.data_in = '0;
        repeat (3) tick();
        check_eq("rst.tx", tx, 1);
        check_eq("rst.txrdy", u_if.txrdy, 1);
        check_eq("rst.rxrdy", u_if.rxrdy, 0);
        check_eq("rst.data", u_if.data_out, 0);
        check_eq("rst.fe", u_if.framing_err, 0);
        check_eq("rst.ov", u_if.overflow, 0);
        rst = 1'b0;
        repeat (3) tick();

        // Single frame, exact cycle timing.
        u_if.data_in = 8'hA5;
        u_if.wen     = 1'b1;
        tick();
        u_if.wen     = 1'b0;
        check_eq("a5.txrdy_t1", u_if.txrdy, 0);
        tick();
        check_eq("a5.txrdy_t2", u_if.txrdy, 1);
        bits = {1'b1, 8'hA5, 1'b0};
        for (int k = 0; k < 10; k++)
            for (int c = 0; c < 10; c++) begin
                check_eq("a5.tx", tx, bits[k]);
                tick();
            end
        check_eq("a5.idle", tx, 1);
        repeat (10) tick();
        expect_tx(8'hA5);

        // Back-to-back frames; a write while full is dropped.
        txq.delete(); txt.delete();
        tx_write(8'h3C);
        wait_txrdy();
        tx_write(8'hC3);
        check_eq("b2b.busy", u_if.txrdy, 0);
        tx_write(8'hEE);
        check_eq("b2b.busy2", u_if.txrdy, 0);
        repeat (250) tick();
        check_eq("b2b.count", txq.size(), 2);
        if (txt.size() >= 2)
            check_eq("b2b.gap", 32'((txt[1] - txt[0]) >= 100 && (txt[1] - txt[0]) <= 101), 1);
        expect_tx(8'h3C);
        expect_tx(8'hC3);

        // Receive path directed cases.
        m_pend = 1'b0; m_data = '0; m_fe = 1'b0; m_ov = 1'b0;
        send_rx(8'h5A, 1'b1, -1);
        lat = rise_idx;
        check_eq("rx.latency", 32'(lat >= 90 && lat <= 102), 1);
        m_pend = 1'b1; m_data = 8'h5A;
        rx_compare("rx5a");
        read_pulse();
        m_pend = 1'b0;
        rx_compare("rx5a_read");
        repeat (5) tick();

        rx = 1'b0;
        repeat (3) tick();
        rx = 1'b1;
        repeat (30) tick();
        rx_compare("glitch");

        send_rx(8'h81, 1'b0, -1);
        repeat (3) tick();
        m_pend = 1'b1; m_data = 8'h81; m_fe = 1'b1;
        rx_compare("fe81");
        repeat (5) tick();

        send_rx(8'h11, 1'b1, -1);
        repeat (3) tick();
        m_ov = 1'b1;
        rx_compare("ovf");
        repeat (5) tick();

        send_rx(8'h11, 1'b1, lat);
        repeat (3) tick();
        m_data = 8'h11; m_fe = 1'b0; m_ov = 1'b0;
        rx_compare("coinc");
        read_pulse();
        m_pend = 1'b0;
        rx_compare("coinc_read");
        repeat (5) tick();

        // Reset in the middle of a TX frame and an RX frame.
        send_rx(8'hC7, 1'b1, -1);
        tx_write(8'h5F);
        repeat (30) tick();
        rx = 1'b0;
        repeat (20) tick();
        rst = 1'b1;
        #1;
        check_eq("midrst.tx", tx, 1);
        check_eq("midrst.txrdy", u_if.txrdy, 1);
        m_pend = 1'b0; m_data = '0; m_fe = 1'b0; m_ov = 1'b0;
        rx_compare("midrst");
        tick();
        rst = 1'b0;
        rx  = 1'b1;
        repeat (120) tick();
        txq.delete(); txt.delete();

        // Randomized transmit.
        for (int i = 0; i < 5; i++) begin
            b = 8'($urandom);
            wait_txrdy();
            tx_write(b);
            exq.push_back(b);
        end
        repeat (350) tick();
        check_eq("rtx.count", txq.size(), 5);
        while (exq.size() != 0) expect_tx(exq.pop_front());

        // Randomized receive against the scoreboard.
        for (int i = 0; i < 8; i++) begin
            b     = 8'($urandom);
            coinc = m_pend && ($urandom_range(0, 2) == 0);
            sb    = (m_pend && !coinc) ? 1'b1 : 1'($urandom_range(0, 1));
            send_rx(b, sb, coinc ? lat : -1);
            if (!m_pend || coinc) begin
                m_data = b; m_pend = 1'b1; m_fe = !sb; m_ov = 1'b0;
            end else begin
                m_ov = 1'b1;
            end
            repeat (3) tick();
            rx_compare("rrx");
            if ($urandom_range(0, 1) == 1) begin
                read_pulse();
                m_pend = 1'b0; m_fe = 1'b0; m_ov = 1'b0;
                rx_compare("rrx_read");
            end
            repeat (5) tick();
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
